// File: rtl/sr_ff_checker.sv
// sr_ff_checker
//   Observing-end reference model of an SR flip-flop. The (s, r) values are
//   sampled at edge n, and q is checked against the predicted value at edge n+1.
//
//   Ports
//     clk          rising-edge clock, shared with the monitored flip-flop
//     rst          synchronous active-high reset
//     en           checking enable
//     s, r         set / reset inputs, as driven to the flip-flop
//     q            registered output of the flip-flop
//     track        high while the model holds a valid prediction
//     err          one-cycle pulse after a q mismatch
//     err_sticky   latched mismatch flag, cleared only by rst
//     mismatch_cnt saturating count of mismatches
//     illegal_cnt  saturating count of en=1 cycles with s=r=1
//     ff_valid/ff_time/ff_exp  first-failure snapshot
//
//   Build option
//     SR_CHK_FIRST_FAIL_EN  When defined, adds a free-running 16-bit cycle
//                           counter and a first-failure capture. When not
//                           defined, ff_* are tied to 0.
module sr_ff_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        s,
  input  logic        r,
  input  logic        q,
  output logic        track,
  output logic        err,
  output logic        err_sticky,
  output logic [7:0]  mismatch_cnt,
  output logic [7:0]  illegal_cnt,
  output logic        ff_valid,
  output logic [15:0] ff_time,
  output logic        ff_exp
);

  typedef enum logic {UNK = 1'b0, TRACK = 1'b1} state_t;

  state_t state;
  logic   pred;      // predicted q for the next edge
  logic   chk_v;     // a compare against pred is armed for the next edge
  logic   illegal;
  logic   mismatch;

  // The compare uses the pred value loaded on the previous edge. The compare is
  // discarded when en is low on the compare edge.
  always_comb begin
    illegal  = en & s & r;
    mismatch = chk_v & en & (q != pred);
  end

  // Model FSM. chk_v and track follow the next state, so a compare is
  // armed exactly when the model leaves this edge in TRACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNK;
      pred  <= 1'b0;
      chk_v <= 1'b0;
      track <= 1'b0;
    end else if (!en) begin
      state <= UNK;
      chk_v <= 1'b0;
      track <= 1'b0;
    end else begin
      case (state)
        UNK: begin
          if (s ^ r) begin
            state <= TRACK;
            pred  <= s;
            chk_v <= 1'b1;
            track <= 1'b1;
          end else begin
            state <= UNK;
            chk_v <= 1'b0;
            track <= 1'b0;
          end
        end
        TRACK: begin
          if (s & r) begin
            // s=r=1 puts the real FF in an undefined state, so pred is left
            // as is and treated as don't-care.
            state <= UNK;
            chk_v <= 1'b0;
            track <= 1'b0;
          end else begin
            state <= TRACK;
            chk_v <= 1'b1;
            track <= 1'b1;
            if (s ^ r) pred <= s;
          end
        end
        default: begin
          state <= UNK;
          chk_v <= 1'b0;
          track <= 1'b0;
        end
      endcase
    end
  end

  // Error reporting and saturating counters. Both counters can step on the
  // same edge, for example when a mismatch coincides with an illegal sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      err          <= 1'b0;
      err_sticky   <= 1'b0;
      mismatch_cnt <= 8'd0;
      illegal_cnt  <= 8'd0;
    end else begin
      err <= mismatch;
      if (mismatch) err_sticky <= 1'b1;
      if (mismatch && (mismatch_cnt != 8'hFF))
        mismatch_cnt <= mismatch_cnt + 8'd1;
      if (illegal && (illegal_cnt != 8'hFF))
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

`ifdef SR_CHK_FIRST_FAIL_EN
  logic [15:0] cyc;

  // The cycle counter wraps naturally from 0xFFFF to 0x0000. ff_time stores
  // the counter value as it stands on the compare edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc      <= 16'd0;
      ff_valid <= 1'b0;
      ff_time  <= 16'd0;
      ff_exp   <= 1'b0;
    end else begin
      cyc <= cyc + 16'd1;
      if (mismatch && !ff_valid) begin
        ff_valid <= 1'b1;
        ff_time  <= cyc;
        ff_exp   <= pred;
      end
    end
  end
`else
  assign ff_valid = 1'b0;
  assign ff_time  = 16'd0;
  assign ff_exp   = 1'b0;
`endif

endmodule

// File: tb/tb_sr_ff_checker.sv
// tb_sr_ff_checker
//   Directed bench for sr_ff_checker. A behavioural model of what is known
//   about the flip-flop is compared with the DUT on every falling edge. Literal
//   hand-computed checks at scenario boundaries pin the model itself.
module tb_sr_ff_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        s   = 1'b0;
  logic        r   = 1'b0;
  logic        q   = 1'b0;
  logic        track, err, err_sticky, ff_valid, ff_exp;
  logic [7:0]  mismatch_cnt, illegal_cnt;
  logic [15:0] ff_time;

  sr_ff_checker dut (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q),
    .track(track), .err(err), .err_sticky(err_sticky),
    .mismatch_cnt(mismatch_cnt), .illegal_cnt(illegal_cnt),
    .ff_valid(ff_valid), .ff_time(ff_time), .ff_exp(ff_exp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  // Model state. "known" means the FF value is determined by the
  // stimulus seen so far. "armed" means a compare is owed on the next edge.
  bit known = 0, kval = 0, armed = 0, aval = 0;
  int m_mis = 0, m_ill = 0, m_cyc = 0, m_fft = 0;
  bit e_err = 0, e_sticky = 0, e_track = 0, e_ffv = 0, e_ffe = 0;

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Advances the model by one rising edge, using the inputs applied at that edge.
  function automatic void model_edge(input bit rr, input bit e, input bit ss,
                                     input bit rv, input bit qq);
    bit miss;
    if (rr) begin
      known = 0; kval = 0; armed = 0; aval = 0;
      m_mis = 0; m_ill = 0; m_cyc = 0; m_fft = 0;
      e_err = 0; e_sticky = 0; e_track = 0; e_ffv = 0; e_ffe = 0;
      return;
    end
    miss  = armed && e && (qq != aval);
    e_err = miss;
    if (miss) begin
      e_sticky = 1;
      m_mis = sat(m_mis + 1);
`ifdef SR_CHK_FIRST_FAIL_EN
      if (!e_ffv) begin e_ffv = 1; m_fft = m_cyc; e_ffe = aval; end
`endif
    end
`ifdef SR_CHK_FIRST_FAIL_EN
    m_cyc = (m_cyc + 1) % 65536;
`endif
    if (e && ss && rv) m_ill = sat(m_ill + 1);
    if (!e || (ss && rv)) known = 0;
    else if (ss != rv) begin known = 1; kval = ss; end
    armed   = known;
    aval    = kval;
    e_track = known;
  endfunction

  task automatic tick(input bit rr, input bit e, input bit ss, input bit rv, input bit qq);
    rst = rr; en = e; s = ss; r = rv; q = qq;
    @(posedge clk);
    model_edge(rr, e, ss, rv, qq);
    @(negedge clk);
  endtask

  // Compare process: runs on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (run) begin
      chk("track",        int'(track),        int'(e_track));
      chk("err",          int'(err),          int'(e_err));
      chk("err_sticky",   int'(err_sticky),   int'(e_sticky));
      chk("mismatch_cnt", int'(mismatch_cnt), m_mis);
      chk("illegal_cnt",  int'(illegal_cnt),  m_ill);
      chk("ff_valid",     int'(ff_valid),     int'(e_ffv));
      chk("ff_time",      int'(ff_time),      m_fft);
      chk("ff_exp",       int'(ff_exp),       int'(e_ffe));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for 2 cycles
    tick(1, 0, 0, 0, 0);
    run = 1'b1;
    tick(1, 0, 0, 0, 0);
    chk("rst_track", int'(track), 0);
    chk("rst_cnts",  int'(mismatch_cnt) + int'(illegal_cnt), 0);

    // Set, then hold for 3 cycles with q=1
    tick(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 1);
    chk("hold_track", int'(track), 1);
    chk("hold_mis",   int'(mismatch_cnt), 0);

    // Reset FF while q stays 1 -> a single err
    tick(0, 1, 0, 1, 1);
    chk("r_no_err_yet", int'(err), 0);
    tick(0, 1, 0, 0, 1);
    chk("r_err",    int'(err), 1);
    chk("r_sticky", int'(err_sticky), 1);
    chk("r_mis",    int'(mismatch_cnt), 1);
`ifdef SR_CHK_FIRST_FAIL_EN
    chk("r_ffv",  int'(ff_valid), 1);
    chk("r_ffe",  int'(ff_exp), 0);
    chk("r_fft",  int'(ff_time), 5);
`endif
    tick(0, 1, 0, 0, 0);
    chk("r_err_once", int'(err), 0);

    // Three illegal samples with q wandering
    tick(0, 1, 1, 1, 0);
    tick(0, 1, 1, 1, 1);
    tick(0, 1, 1, 1, 0);
    chk("ill_cnt",   int'(illegal_cnt), 3);
    chk("ill_track", int'(track), 0);
    chk("ill_err",   int'(err), 0);
    tick(0, 1, 1, 0, 0);
    chk("ill_retrack", int'(track), 1);

    // Mismatch and illegal sample on the same edge
    tick(0, 1, 1, 1, 0);
    chk("both_err", int'(err), 1);
    chk("both_mis", int'(mismatch_cnt), 2);
    chk("both_ill", int'(illegal_cnt), 4);
    chk("both_trk", int'(track), 0);

    // Saturation: first set arms, then 300 mismatches
    for (int i = 0; i < 301; i++) tick(0, 1, 1, 0, 0);
    chk("sat_mis", int'(mismatch_cnt), 255);
    chk("sat_ill", int'(illegal_cnt), 4);

    // Reset on the edge right after a mismatching set
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    tick(1, 1, 0, 0, 0);
    chk("rst_mid_err",    int'(err), 0);
    chk("rst_mid_sticky", int'(err_sticky), 0);
    chk("rst_mid_mis",    int'(mismatch_cnt), 0);
    chk("rst_mid_track",  int'(track), 0);
    chk("rst_mid_ffv",    int'(ff_valid), 0);
    tick(0, 0, 0, 0, 0);
    chk("after_rst_err", int'(err), 0);

    // en low for 2 cycles while toggling s/r
    tick(0, 1, 1, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 1, 1, 1);
    chk("en0_track", int'(track), 0);
    chk("en0_err",   int'(err), 0);
    chk("en0_mis",   int'(mismatch_cnt), 0);
    chk("en0_ill",   int'(illegal_cnt), 0);
    tick(0, 1, 1, 0, 1);
    tick(0, 1, 0, 0, 0);
    chk("resume_err", int'(err), 1);
    chk("resume_mis", int'(mismatch_cnt), 1);

    tick(0, 1, 0, 0, 1);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
